// File: rtl/rf_writeback_queue_pkg.sv
// Shared register-file constants and the writeback queue entry type.
// Pure declarations, no timing.
// Used by the writeback queue and its FIFO.
package rf_writeback_queue_pkg;

  localparam int REG_IDX_W = 5;
  localparam int XLEN      = 32;
  localparam int REG_COUNT = 32;
  localparam logic [REG_IDX_W-1:0] X0_IDX = '0;

  typedef struct packed {
    logic [REG_IDX_W-1:0] rd;
    logic [XLEN-1:0]      val;
  } wb_entry_t;

  function automatic logic is_x0(input logic [REG_IDX_W-1:0] idx);
    return idx == X0_IDX;
  endfunction

endpackage

// File: rtl/rf_writeback_queue_wb_fifo.sv
// In-order FIFO with two ordered push ports (push0 older) and one pop port.
// Head is combinational from registered state; pushes visible next cycle.
// No internal backpressure: the caller sizes pushes against the free output.
module wb_fifo
  import rf_writeback_queue_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int PTR_W  = $clog2(DEPTH),
  parameter int QCNT_W = $clog2(DEPTH) + 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_push0_vld,
  input  wb_entry_t         i_push0_dat,
  input  logic              i_push1_vld,
  input  wb_entry_t         i_push1_dat,
  input  logic              i_pop,
  output wb_entry_t         o_head_dat,
  output logic [QCNT_W-1:0] o_count,
  output logic [QCNT_W-1:0] o_free
);

  wb_entry_t          mem_q [DEPTH];
  wb_entry_t          mem_d [DEPTH];
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [QCNT_W-1:0]  count_q, count_d;
  logic               pop_ok;

  assign pop_ok     = i_pop && (count_q != '0);
  assign o_count    = count_q;
  // A same-cycle pop hands its slot to this cycle's pushes.
  assign o_free     = QCNT_W'(DEPTH) - count_q + QCNT_W'(pop_ok);
  assign o_head_dat = (count_q != '0) ? mem_q[rd_ptr_q] : '0;

  // Next pointers, occupancy and storage; push0 lands ahead of push1.
  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (pop_ok) rd_ptr_d = rd_ptr_q + 1'b1;
    if (i_push0_vld) begin
      mem_d[wr_ptr_d] = i_push0_dat;
      wr_ptr_d        = wr_ptr_d + 1'b1;
    end
    if (i_push1_vld) begin
      mem_d[wr_ptr_d] = i_push1_dat;
      wr_ptr_d        = wr_ptr_d + 1'b1;
    end
    count_d = count_q - QCNT_W'(pop_ok) + QCNT_W'(i_push0_vld) + QCNT_W'(i_push1_vld);
  end

  // Pointer and count registers; storage contents need no reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage.
  always_ff @(posedge i_clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/rf_writeback_queue.sv
// Collects ALU/LSU results into an in-order queue and writes one per cycle into the RF.
// Accepted result reaches o_rf_* the next cycle at the earliest; per-register busy scoreboard.
// Producers are throttled by free queue slots; reservations by saturated pending counters.
module rf_writeback_queue
  import rf_writeback_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_rsv_valid,
  input  logic [REG_IDX_W-1:0] i_rsv_rd,
  output logic                 o_rsv_ready,
  input  logic                 i_alu_valid,
  input  logic [REG_IDX_W-1:0] i_alu_rd,
  input  logic [XLEN-1:0]      i_alu_val,
  output logic                 o_alu_ready,
  input  logic                 i_lsu_valid,
  input  logic [REG_IDX_W-1:0] i_lsu_rd,
  input  logic [XLEN-1:0]      i_lsu_val,
  output logic                 o_lsu_ready,
  input  logic [REG_IDX_W-1:0] i_rs1,
  input  logic [REG_IDX_W-1:0] i_rs2,
  output logic                 o_rs1_busy,
  output logic                 o_rs2_busy,
  output logic                 o_rf_we,
  output logic [REG_IDX_W-1:0] o_rf_rd,
  output logic [XLEN-1:0]      o_rf_val
);

  localparam int QCNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  wb_entry_t         head;
  wb_entry_t         lsu_ent, alu_ent;
  logic [QCNT_W-1:0] count, free;
  logic              pop, lsu_push, alu_push, rsv_fire;
  logic [CNT_W-1:0]  cnt_q [REG_COUNT];
  logic [CNT_W-1:0]  cnt_d [REG_COUNT];

  // The RF never stalls, so the head retires whenever the queue holds anything.
  assign pop      = (count != '0);
  assign o_rf_we  = pop;
  assign o_rf_rd  = head.rd;
  assign o_rf_val = head.val;

  // LSU has priority on the last slot; ALU needs a second slot only when LSU competes.
  assign o_lsu_ready = (free >= QCNT_W'(1));
  assign o_alu_ready = (free >= QCNT_W'(2)) || ((free >= QCNT_W'(1)) && !i_lsu_valid);

  // x0 results handshake normally but never occupy the queue.
  assign lsu_push = i_lsu_valid && o_lsu_ready && !is_x0(i_lsu_rd);
  assign alu_push = i_alu_valid && o_alu_ready && !is_x0(i_alu_rd);
  assign lsu_ent  = '{rd: i_lsu_rd, val: i_lsu_val};
  assign alu_ent  = '{rd: i_alu_rd, val: i_alu_val};

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_push0_vld (lsu_push || alu_push),
    .i_push0_dat (lsu_push ? lsu_ent : alu_ent),
    .i_push1_vld (lsu_push && alu_push),
    .i_push1_dat (alu_ent),
    .i_pop       (pop),
    .o_head_dat  (head),
    .o_count     (count),
    .o_free      (free)
  );

  // A retiring write to the same register frees a count in the same cycle.
  assign o_rsv_ready = (cnt_q[i_rsv_rd] != CNT_MAX) || (o_rf_we && (o_rf_rd == i_rsv_rd));
  assign rsv_fire    = i_rsv_valid && o_rsv_ready && !is_x0(i_rsv_rd);
  assign o_rs1_busy  = !is_x0(i_rs1) && (cnt_q[i_rs1] != '0);
  assign o_rs2_busy  = !is_x0(i_rs2) && (cnt_q[i_rs2] != '0);

  // Pending-write counters: +1 per reservation, -1 per RF strobe, floor at zero.
  always_comb begin
    for (int r = 0; r < REG_COUNT; r++) begin
      cnt_d[r] = cnt_q[r];
      if (rsv_fire && (i_rsv_rd == REG_IDX_W'(r)) &&
          !(o_rf_we && (o_rf_rd == REG_IDX_W'(r)))) begin
        cnt_d[r] = cnt_q[r] + 1'b1;
      end else if (o_rf_we && (o_rf_rd == REG_IDX_W'(r)) &&
                   !(rsv_fire && (i_rsv_rd == REG_IDX_W'(r))) &&
                   (cnt_q[r] != '0)) begin
        cnt_d[r] = cnt_q[r] - 1'b1;
      end
    end
  end

  // Counter registers.
  always_ff @(posedge i_clk) begin
    for (int r = 0; r < REG_COUNT; r++) begin
      cnt_q[r] <= i_rst ? '0 : cnt_d[r];
    end
  end

endmodule
